// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a byte-enabled write port, optional write-to-read
// bypass, synchronous bulk clear and a per-entry "written since reset/clear" scoreboard.
module reg_file_mp #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 8,
   parameter  int NUM_RD = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(DEPTH),
   localparam int NB     = WIDTH / 8
) (
   input  logic                    Clk,
   input  logic                    reset_n,
   input  logic                    clr,
   input  logic                    we,
   input  logic [AW-1:0]           wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic [NB-1:0]           wr_be,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [DEPTH-1:0]        written
);

   logic [DEPTH-1:0][WIDTH-1:0] store;

   function automatic logic [WIDTH-1:0] mergeBytes(input logic [WIDTH-1:0] oldWord,
                                                   input logic [WIDTH-1:0] newWord,
                                                   input logic [NB-1:0]    be);
      logic [WIDTH-1:0] res;
      res = oldWord;
      for (int b = 0; b < NB; b++) begin
         if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
      end
      return res;
   endfunction

   // Per-entry decode compares against each in-range index, so an address >= DEPTH never hits
   // and an X address cannot qualify any entry unless we is high.
   for (genvar k = 0; k < DEPTH; k++) begin : g_entry
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic             written_q;
      logic             written_d;
      logic             hit;

      assign hit = we && (wr_addr == AW'(k)) && (wr_be != '0);

      always_comb begin
         data_d    = data_q;
         written_d = written_q;
         if (clr) begin
            data_d    = '0;
            written_d = 1'b0;
         end else if (hit) begin
            data_d    = mergeBytes(data_q, wr_data, wr_be);
            written_d = 1'b1;
         end
      end

      always_ff @(posedge Clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q    <= '0;
            written_q <= 1'b0;
         end else begin
            data_q    <= data_d;
            written_q <= written_d;
         end
      end

      assign store[k]   = data_q;
      assign written[k] = written_q;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] portData;
      logic             fwd;

      assign addr = rd_addr[p*AW +: AW];

      // Out-of-range addresses match no entry and fall through to zero.
      always_comb begin
         stored = '0;
         for (int k = 0; k < DEPTH; k++) begin
            if (addr == AW'(k)) stored = store[k];
         end
      end

      assign fwd      = (BYPASS != 0) && reset_n && we && !clr && (addr == wr_addr)
                        && (stored == stored) && addrInRange(addr);
      assign portData = fwd ? mergeBytes(stored, wr_data, wr_be) : stored;
      assign rd_data[p*WIDTH +: WIDTH] = portData;
   end

   function automatic logic addrInRange(input logic [AW-1:0] a);
      logic hitAny;
      hitAny = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (a == AW'(k)) hitAny = 1'b1;
      end
      return hitAny;
   endfunction

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: three instances (bypass, no bypass, DEPTH=6) share
// stimulus and are compared against an array-based reference model.
module tb_reg_file_mp;

   logic        clock = 1'b0;
   logic        resetN;
   logic        clr;
   logic        we;
   logic [2:0]  wrAddr;
   logic [15:0] wrData;
   logic [1:0]  wrBe;
   logic [5:0]  rdAddr;
   logic [31:0] rdData0, rdData1, rdData2;
   logic [7:0]  written0, written1;
   logic [5:0]  written2;

   int checks = 0;
   int errors = 0;

   logic [15:0] modelMem [3][8];
   logic [7:0]  modelWritten [3];
   int          depthOf  [3] = '{8, 8, 6};
   bit          bypassOf [3] = '{1'b1, 1'b0, 1'b1};

   always #5 clock = ~clock;

   reg_file_mp #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .BYPASS(1)) dutBp (
      .Clk(clock), .reset_n(resetN), .clr(clr), .we(we), .wr_addr(wrAddr),
      .wr_data(wrData), .wr_be(wrBe), .rd_addr(rdAddr), .rd_data(rdData0), .written(written0));

   reg_file_mp #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .BYPASS(0)) dutNb (
      .Clk(clock), .reset_n(resetN), .clr(clr), .we(we), .wr_addr(wrAddr),
      .wr_data(wrData), .wr_be(wrBe), .rd_addr(rdAddr), .rd_data(rdData1), .written(written1));

   reg_file_mp #(.WIDTH(16), .DEPTH(6), .NUM_RD(2), .BYPASS(1)) dutD6 (
      .Clk(clock), .reset_n(resetN), .clr(clr), .we(we), .wr_addr(wrAddr),
      .wr_data(wrData), .wr_be(wrBe), .rd_addr(rdAddr), .rd_data(rdData2), .written(written2));

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic weV, input logic [2:0] addr, input logic [15:0] data,
                                input logic [1:0] be, input logic clrV,
                                input logic [2:0] r0, input logic [2:0] r1);
      we     = weV;
      wrAddr = addr;
      wrData = data;
      wrBe   = be;
      clr    = clrV;
      rdAddr = {r1, r0};
   endtask

   task automatic resetModels();
      for (int i = 0; i < 3; i++) begin
         for (int a = 0; a < 8; a++) modelMem[i][a] = 16'h0;
         modelWritten[i] = 8'h0;
      end
   endtask

   // Applies the effect of one rising edge to every model instance.
   task automatic updateModels();
      if (!resetN || clr) begin
         resetModels();
      end else if (we && wrBe != 2'b00) begin
         for (int i = 0; i < 3; i++) begin
            if (int'(wrAddr) < depthOf[i]) begin
               for (int b = 0; b < 2; b++)
                  if (wrBe[b]) modelMem[i][wrAddr][8*b +: 8] = wrData[8*b +: 8];
               modelWritten[i][wrAddr] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [15:0] expectRead(input int i, input int a);
      logic [15:0] v;
      if (a >= depthOf[i]) return 16'h0;
      v = modelMem[i][a];
      if (bypassOf[i] && resetN && we && !clr && a == int'(wrAddr)) begin
         for (int b = 0; b < 2; b++)
            if (wrBe[b]) v[8*b +: 8] = wrData[8*b +: 8];
      end
      return v;
   endfunction

   function automatic logic [15:0] observedRead(input int i, input int p);
      case (i)
         0:       return rdData0[16*p +: 16];
         1:       return rdData1[16*p +: 16];
         default: return rdData2[16*p +: 16];
      endcase
   endfunction

   function automatic logic [7:0] observedWritten(input int i);
      case (i)
         0:       return written0;
         1:       return written1;
         default: return {2'b00, written2};
      endcase
   endfunction

   task automatic checkAll(input string tag);
      for (int i = 0; i < 3; i++) begin
         for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("%s/rd i%0d p%0d a%0d", tag, i, p, rdAddr[3*p +: 3]),
                        {16'h0, observedRead(i, p)}, {16'h0, expectRead(i, int'(rdAddr[3*p +: 3]))});
         end
         checkOutput($sformatf("%s/written i%0d", tag, i),
                     {24'h0, observedWritten(i)}, {24'h0, modelWritten[i]});
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      updateModels();
      #1;
   endtask

   initial begin
      resetN = 1'b0;
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 3'd1);
      resetModels();
      #3 checkAll("reset");
      #4 resetN = 1'b1;
      cycle();

      applyStimulus(1'b1, 3'd3, 16'hBEEF, 2'b11, 1'b0, 3'd3, 3'd3);
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd3, 3'd3);
      #1 checkAll("r3Stored");
      resetN = 1'b0;
      resetModels();
      #1 checkAll("asyncReset");
      #2 resetN = 1'b1;
      cycle();

      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 3'(k), 16'h1111 * 16'(k), 2'b11, 1'b0, 3'd0, 3'd0);
         cycle();
      end
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'(k), 3'(7 - k));
         #1 checkAll("writeAll");
      end

      applyStimulus(1'b1, 3'd2, 16'hA5A5, 2'b11, 1'b0, 3'd2, 3'd4);
      cycle();
      applyStimulus(1'b1, 3'd2, 16'h1234, 2'b01, 1'b0, 3'd2, 3'd4);
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd2, 3'd4);
      #1 checkAll("byteEnable");
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd2, 3'd4);
      cycle();
      applyStimulus(1'b1, 3'd4, 16'hFFFF, 2'b00, 1'b0, 3'd4, 3'd2);
      #1 checkAll("zeroBeComb");
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd4, 3'd2);
      #1 checkAll("zeroBe");

      applyStimulus(1'b1, 3'd5, 16'h00FF, 2'b11, 1'b0, 3'd5, 3'd0);
      cycle();
      applyStimulus(1'b1, 3'd5, 16'hAB00, 2'b10, 1'b0, 3'd5, 3'd0);
      #1 checkAll("bypassBefore");
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd5, 3'd0);
      #1 checkAll("bypassAfter");

      applyStimulus(1'b1, 3'd1, 16'h4242, 2'b11, 1'b0, 3'd1, 3'd5);
      cycle();
      applyStimulus(1'b1, 3'd1, 16'h7777, 2'b11, 1'b1, 3'd1, 3'd5);
      #1 checkAll("clrWriteComb");
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd1, 3'd5);
      #1 checkAll("clrWrite");

      applyStimulus(1'b1, 3'd7, 16'hFFFF, 2'b11, 1'b0, 3'd7, 3'd6);
      #1 checkAll("outOfRangeComb");
      cycle();
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd6, 3'd7);
      #1 checkAll("outOfRange");

      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         #1 checkAll("random");
         if (n == 200) begin
            resetN = 1'b0;
            resetModels();
            #1 checkAll("randomReset");
            #1 resetN = 1'b1;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
